// File: rtl/maxnet_pkg.sv
// Shared widths, state encoding and default weights for the MaxNet controller.
package maxnet_pkg;

    localparam int unsigned X_W    = 5;
    localparam int unsigned PROD_W = 10;
    localparam int unsigned SUM_W  = 12;
    localparam int unsigned N_PU   = 4;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned IDX_W  = 2;

    // Q1.4 signed: +15/16 on the diagonal, -2/16 off the diagonal
    localparam logic [X_W-1:0] W_SELF_DEF = 5'b01111;
    localparam logic [X_W-1:0] W_INH_DEF  = 5'b11110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_CAPTURE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/maxnet_if.sv
// Controller <-> PU / host bundle for the 4-neuron MaxNet.
interface maxnet_if;
    import maxnet_pkg::*;

    logic                             start;
    logic [N_PU-1:0][X_W-1:0]         x_in;
    logic [N_PU-1:0][SUM_W-1:0]       pu_out;
    logic [N_PU-1:0][X_W-1:0]         pu_x;
    logic [X_W-1:0]                   w_self;
    logic [X_W-1:0]                   w_inh;
    logic                             busy;
    logic                             done;
    logic                             found;
    logic [IDX_W-1:0]                 winner;
    logic [ITER_W-1:0]                iter_count;

    // controller side
    modport master (
        input  start, x_in, pu_out,
        output pu_x, w_self, w_inh, busy, done, found, winner, iter_count
    );

    // host / PU side
    modport slave (
        output start, x_in, pu_out,
        input  pu_x, w_self, w_inh, busy, done, found, winner, iter_count
    );

endinterface

// File: rtl/maxnet_relu_trunc.sv
// ReLU plus saturating truncation of a Q4.8 PU sum back to a Q1.4 activation.
module relu_trunc
    import maxnet_pkg::*;
(
    input  logic [SUM_W-1:0] v,
    output logic [X_W-1:0]   res_c
);

    // negative -> 0, integer part set -> max positive, else drop low fraction bits
    always_comb begin
        res_c = '0;
        if (v[SUM_W-1]) begin
            res_c = '0;
        end else if (v[10:8] != 3'd0) begin
            res_c = 5'b01111;
        end else begin
            res_c = {1'b0, v[7:4]};
        end
    end

endmodule

// File: rtl/maxnet_ctrl.sv
// MaxNet iteration controller: loads activations, iterates PU sums, reports winner.
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter int unsigned    MAX_ITER = 15,
    parameter logic [X_W-1:0] W_SELF   = W_SELF_DEF,
    parameter logic [X_W-1:0] W_INH    = W_INH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    maxnet_if.master bus
);

    state_t                   state, state_nx;
    logic [N_PU-1:0][X_W-1:0] x_q, x_nx, relu_c;
    logic [ITER_W-1:0]        iter_q, iter_nx;
    logic                     found_q, found_nx;
    logic [IDX_W-1:0]         win_q, win_nx;
    logic                     busy_q, busy_nx;
    logic                     done_q, done_nx;
    logic [2:0]               nz_c;
    logic [IDX_W-1:0]         idx_c;

    // one saturating ReLU per neuron
    for (genvar g = 0; g < N_PU; g++) begin : g_relu
        relu_trunc u_relu (
            .v     (bus.pu_out[g]),
            .res_c (relu_c[g])
        );
    end

    // count of surviving neurons and index of the (last) survivor
    always_comb begin
        nz_c  = '0;
        idx_c = '0;
        for (int i = 0; i < N_PU; i++) begin
            if (x_q[i] != '0) begin
                nz_c  = nz_c + 3'd1;
                idx_c = IDX_W'(i);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // next state and next register values
    always_comb begin
        state_nx = state;
        x_nx     = x_q;
        iter_nx  = iter_q;
        found_nx = found_q;
        win_nx   = win_q;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_LOAD;
            ST_LOAD: begin
                x_nx     = bus.x_in;
                iter_nx  = '0;
                found_nx = 1'b0;
                win_nx   = '0;
                state_nx = ST_CHECK;
            end
            ST_RUN:  state_nx = ST_WAIT;
            ST_WAIT: state_nx = ST_CAPTURE;
            ST_CAPTURE: begin
                x_nx     = relu_c;
                iter_nx  = iter_q + ITER_W'(1);
                state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (nz_c == 3'd1) begin
                    found_nx = 1'b1;
                    win_nx   = idx_c;
                    state_nx = ST_DONE;
                end else if (nz_c == 3'd0) begin
                    state_nx = ST_DONE;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: if (bus.start) state_nx = ST_LOAD;
            default: state_nx = ST_IDLE;
        endcase
        busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_DONE);
        done_nx = (state_nx == ST_DONE);
    end

    // registered datapath and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            iter_q  <= '0;
            found_q <= 1'b0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_nx;
            iter_q  <= iter_nx;
            found_q <= found_nx;
            win_q   <= win_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    assign bus.pu_x       = x_q;
    assign bus.w_self     = W_SELF;
    assign bus.w_inh      = W_INH;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.found      = found_q;
    assign bus.winner     = win_q;
    assign bus.iter_count = iter_q;

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
- Iteration controller for the 4-neuron MaxNet; sits on the opposite side of the four processing units (PUs).
- Loads four activations and drives the shared x bus plus self/inhibit weights into the PUs.
- Captures the four 12-bit PU sums, applies ReLU plus truncation back to 5 bits, and writes the results back.
- Repeats until exactly one neuron is non-zero, all neurons are zero, or the iteration limit is reached, then reports the winner.

Parameters:
- MAX_ITER, 15: iteration limit; 1..15 (iteration counter is 4 bits).
- W_SELF, 5'b01111: diagonal weight, Q1.4 signed (+15/16).
- W_INH, 5'b11110: off-diagonal weight, Q1.4 signed (-2/16 = -epsilon).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
- x_in0..x_in3  in  5 each  initial activations, Q1.4, non-negative (bit4 = 0).
- pu_out0..pu_out3  in  12 each  PU i result, Q4.8 signed. Fixed PU latency is 2 cycles from x/w to pu_out.
- pu_x0..pu_x3  out  5 each  current activations, broadcast to every PU.
- w_self, w_inh  out  5 each  constant W_SELF and W_INH. Top level wires row i so that PU i gets w_self on lane i and w_inh elsewhere.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- found  out  1  valid while done; 1 means exactly one neuron survived.
- winner  out  2  index of the survivor; 0 when found = 0.
- iter_count  out  4  iterations completed.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting it forces the following:
  - State goes to IDLE.
  - x registers, iter_count, winner, found, busy and done all go to 0.
  - w_self and w_inh are constants and are not affected by reset.
  - Reset mid-iteration abandons the iteration; any in-flight pu_out is ignored.
- States and transitions:
  - IDLE, on start: go to LOAD.
  - LOAD (1 cycle): x_i <= x_in_i; iter_count <= 0; go to CHECK. Zero iterations are therefore possible.
  - RUN (cycle 0): x is stable on pu_x; PU multiply registers capture at the end of this cycle.
  - WAIT (cycle 1): x held stable.
  - CAPTURE (cycle 2): pu_out is valid. x_i <= relu_trunc(pu_out_i); iter_count increments; go to CHECK.
  - CHECK: nz = number of x_i != 0.
    - nz == 1: go to DONE with found = 1 and winner = index of the non-zero neuron.
    - nz == 0: go to DONE with found = 0.
    - iter_count == MAX_ITER: go to DONE with found = 0 (timeout).
    - Otherwise: go to RUN.
  - DONE: holds all outputs. On start, go to LOAD; found and winner clear in LOAD.
- Timing: each iteration costs 4 cycles (RUN, WAIT, CAPTURE, CHECK). Latency from start to done is 3 + 4*N cycles for N iterations.
- start is ignored in LOAD, RUN, WAIT, CAPTURE and CHECK.
- relu_trunc(v), where v is 12-bit Q4.8:
  - v[11] = 1 gives 0.
  - v[10:8] != 0 saturates to 5'b01111.
  - Otherwise the result is {1'b0, v[7:4]}, i.e. truncation toward zero.
- pu_x outputs are the x registers directly, with no combinational path from any input.

Decomposition:
- Shared package maxnet_pkg holds:
  - X_W = 5, PROD_W = 10, SUM_W = 12.
  - The state encoding (IDLE, LOAD, RUN, WAIT, CAPTURE, CHECK, DONE).
  - Default W_SELF and W_INH.
- One sub-module, relu_trunc (12-bit in, 5-bit out), instantiated four times.
- The non-zero count and one-hot-to-index logic stay inline.

Test Plan:
- Bench model of the PU computes the 4-term sum with 2-cycle latency. Defaults used unless stated.
- Scenario 1: x_in = 8,4,2,0 -> x goes 6,2,0,0 then 5,1,0,0 then 4,0,0,0. Expect done, found = 1, winner = 0, iter_count = 3, with done rising 15 cycles after start.
- Scenario 2: x_in = 5,5,0,0 (tie) -> x goes 4,4 / 3,3 / 2,2 / 1,1 / 0,0. Expect found = 0, winner = 0, iter_count = 5.
- Scenario 3: x_in = 0,0,9,0 -> expect DONE straight from the first CHECK with found = 1, winner = 2, iter_count = 0, 3 cycles after start.
- Scenario 4: MAX_ITER = 2, x_in = 5,5,0,0 -> expect found = 0, iter_count = 2, x = 3,3,0,0.
- Scenario 5: relu_trunc unit checks -> 12'hF80 gives 0, 12'h100 gives 15, 12'h06C gives 6.
  - Also: a start pulse during RUN is ignored.
  - Also: rst low during WAIT clears all outputs within the same cycle and stays in IDLE until the next start.
